serial_tx: RTL and testbench
============================

Name: serial_tx

Overview:
- Tick-paced serial transmitter that sits directly downstream of the 4-cycle bit timer.
- It consumes the timer's trigger pulse as its bit tick and drives the timer's clear and enable inputs.
- It accepts one parallel word per valid/ready handshake and shifts it out on a single line as start bit, data LSB-first, optional parity, and stop bit(s).
- With the timer enabled every cycle, each serial bit lasts exactly 4 clk cycles.

Parameters:
- DATA_WIDTH, 8: number of data bits per frame (legal range 5..16).
- STOP_BITS, 1: number of stop bits (1 or 2).
- PARITY_EN, 0: 1 = append one parity bit after the data bits.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- sync_reset  input  1  synchronous, active-high reset; sampled on rising edge of clk.
- tx_data  input  DATA_WIDTH  word to transmit; captured at handshake.
- tx_valid  input  1  upstream has a word on tx_data.
- tx_ready  output  1  block can accept a word; high only in IDLE.
- tick  input  1  bit-period pulse; connect to timer trigger.
- timer_clear  output  1  connect to timer clear; high in IDLE.
- timer_enable  output  1  connect to timer enable; high in every non-IDLE state.
- tx_line  output  1  serial output; idles high.
- busy  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, sync_reset.
- Reset state (next edge with sync_reset=1): state=IDLE, tx_line=1, tx_ready=1, busy=0, timer_clear=1, timer_enable=0, bit index=0, stop count=0. Reset overrides every other input, including mid-frame: the frame is abandoned and tx_line returns high on that same edge.
- States: IDLE, START, DATA, PARITY, STOP. State, shift register, bit index, stop counter and tx_line are registers. tx_ready, busy, timer_clear and timer_enable are decoded from state only; none of them depend combinationally on tx_valid or tick.
- IDLE:
  - tx_line=1, timer_clear=1, timer_enable=0.
  - tick is ignored.
  - If tx_valid=1, then on that edge: shift_reg<=tx_data, state<=START, tx_line<=0.
- START: timer_clear=0, timer_enable=1. On tick: state<=DATA, idx<=0, tx_line<=shift_reg[0].
- DATA: on tick:
  - If idx<DATA_WIDTH-1: shift_reg shifts right, idx<=idx+1, tx_line<=next bit.
  - Otherwise, if PARITY_EN=1: state<=PARITY, tx_line<=parity.
  - Otherwise: state<=STOP, tx_line<=1, stopcnt<=0.
- Parity: XOR of the captured word, inverted when PARITY_ODD=1. It is computed from the word latched at handshake; later changes on tx_data have no effect.
- PARITY: on tick: state<=STOP, tx_line<=1, stopcnt<=0.
- STOP: tx_line=1. On tick: if stopcnt<STOP_BITS-1, stopcnt<=stopcnt+1; otherwise state<=IDLE.
- Timing:
  - Timer is cleared throughout IDLE and counts from 0 on the first START cycle, so tick arrives in the 4th cycle of each bit.
  - Every bit, including start, parity and stop, is held for exactly 4 cycles.
  - Frame length = 4 × (1 + DATA_WIDTH + PARITY_EN + STOP_BITS) cycles; 40 cycles for 8N1.
- Back-to-back: tx_ready is low for the whole frame. At least one IDLE cycle separates frames, so with tx_valid held high the start edges are frame_len+1 cycles apart.
- Handshake is the edge where tx_valid & tx_ready are both high. tx_valid without tx_ready is held off with no effect. Dropping tx_valid mid-frame has no effect.
- A spurious tick while the timer is cleared (IDLE) is ignored. Ticks in other states advance exactly one bit each.

Test Plan:
1. 8N1 defaults, send 0xA5, timer instance attached.
   - tx_line = 0,1,0,1,0,0,1,0,1,1, each value 4 cycles.
   - busy high 40 cycles; tx_ready returns 1 on cycle 41.
2. PARITY_EN=1, send 0xA5.
   - PARITY_ODD=0: parity bit 0. PARITY_ODD=1: parity bit 1.
   - Frame is 44 cycles in both cases.
3. STOP_BITS=2, send 0x00.
   - Line low for 36 cycles (start + 8 data bits), then high 8 cycles.
   - tx_ready rises after cycle 44.
4. tx_valid held high with 0x3C then 0xC3.
   - Second start bit begins 41 cycles after the first.
   - 0x3C is not corrupted when tx_data changes mid-frame.
5. Assert sync_reset at cycle 17 of a frame (mid-data).
   - Next edge: tx_line=1, busy=0, tx_ready=1, timer_clear=1.
   - A new 0x5A then transmits correctly.
6. Drive tick high for 10 cycles while IDLE with tx_valid=0: no state change, tx_line stays 1. Then use a tick stub pulsing every 7 cycles: every bit lasts 7 cycles.

Source files
------------

// File: rtl/serial_tx_if.sv
// rtl/serial_tx_if.sv - valid/ready word handshake into the serial transmitter
interface serial_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/serial_tx.sv
// rtl/serial_tx.sv - tick-paced serial transmitter: start, LSB-first data, optional parity, stop bits
module serial_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic        clk,
    input  logic        sync_reset,
    serial_tx_if.slave  tx_if,
    input  logic        tick,
    output logic        timer_clear,
    output logic        timer_enable,
    output logic        tx_line,
    output logic        busy
);
    localparam int IDX_W = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_stop;
    logic                  r_line;
    logic                  r_parity;

    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic                  w_stop_nxt;
    logic                  w_line_nxt;
    logic                  w_parity_nxt;
    logic                  w_idle;

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_idx    <= '0;
            r_stop   <= 1'b0;
            r_line   <= 1'b1;
            r_parity <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_shift  <= w_shift_nxt;
            r_idx    <= w_idx_nxt;
            r_stop   <= w_stop_nxt;
            r_line   <= w_line_nxt;
            r_parity <= w_parity_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_idx_nxt    = r_idx;
        w_stop_nxt   = r_stop;
        w_line_nxt   = r_line;
        w_parity_nxt = r_parity;
        case (r_state)
            S_IDLE: begin
                w_line_nxt = 1'b1;
                if (tx_if.tx_valid) begin
                    w_shift_nxt  = tx_if.tx_data;
                    // Parity is frozen from the handshake word so later tx_data changes cannot leak in
                    w_parity_nxt = (^tx_if.tx_data) ^ (PARITY_ODD != 0);
                    w_state_nxt  = S_START;
                    w_line_nxt   = 1'b0;
                end
            end
            S_START: begin
                if (tick) begin
                    w_state_nxt = S_DATA;
                    w_idx_nxt   = '0;
                    w_line_nxt  = r_shift[0];
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (r_idx < IDX_W'(DATA_WIDTH - 1)) begin
                        w_shift_nxt = r_shift >> 1;
                        w_idx_nxt   = r_idx + IDX_W'(1);
                        w_line_nxt  = r_shift[1];
                    end else if (PARITY_EN != 0) begin
                        w_state_nxt = S_PARITY;
                        w_line_nxt  = r_parity;
                    end else begin
                        w_state_nxt = S_STOP;
                        w_line_nxt  = 1'b1;
                        w_stop_nxt  = 1'b0;
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    w_state_nxt = S_STOP;
                    w_line_nxt  = 1'b1;
                    w_stop_nxt  = 1'b0;
                end
            end
            S_STOP: begin
                w_line_nxt = 1'b1;
                if (tick) begin
                    if (r_stop < 1'(STOP_BITS - 1)) begin
                        w_stop_nxt = r_stop + 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_line_nxt  = 1'b1;
            end
        endcase
    end

    assign w_idle         = (r_state == S_IDLE);
    assign tx_if.tx_ready = w_idle;
    assign busy           = ~w_idle;
    assign timer_clear    = w_idle;
    assign timer_enable   = ~w_idle;
    assign tx_line        = r_line;
endmodule

// File: tb/tb_serial_tx.sv
// tb/tb_serial_tx.sv - directed checks of serial_tx in 8N1, 8E1, 8O1 and 8N2 configurations
module tb_serial_tx;
    logic       clk = 1'b0;
    logic       sync_reset = 1'b1;
    logic [7:0] tb_data = 8'h00;
    logic [3:0] valid = 4'b0000;
    logic       force_tick = 1'b0;
    logic [2:0] period0 = 3'd4;

    logic [3:0] line, busy, ready, clr, en, tick;
    logic [2:0] tcnt [4];

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    serial_tx_if #(.DATA_WIDTH(8)) if0 ();
    serial_tx_if #(.DATA_WIDTH(8)) if1 ();
    serial_tx_if #(.DATA_WIDTH(8)) if2 ();
    serial_tx_if #(.DATA_WIDTH(8)) if3 ();

    assign if0.tx_data = tb_data;  assign if0.tx_valid = valid[0];  assign ready[0] = if0.tx_ready;
    assign if1.tx_data = tb_data;  assign if1.tx_valid = valid[1];  assign ready[1] = if1.tx_ready;
    assign if2.tx_data = tb_data;  assign if2.tx_valid = valid[2];  assign ready[2] = if2.tx_ready;
    assign if3.tx_data = tb_data;  assign if3.tx_valid = valid[3];  assign ready[3] = if3.tx_ready;

    serial_tx #(.DATA_WIDTH(8), .STOP_BITS(1), .PARITY_EN(0), .PARITY_ODD(0)) u_8n1 (
        .clk(clk), .sync_reset(sync_reset), .tx_if(if0.slave), .tick(tick[0]),
        .timer_clear(clr[0]), .timer_enable(en[0]), .tx_line(line[0]), .busy(busy[0]));
    serial_tx #(.DATA_WIDTH(8), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(0)) u_8e1 (
        .clk(clk), .sync_reset(sync_reset), .tx_if(if1.slave), .tick(tick[1]),
        .timer_clear(clr[1]), .timer_enable(en[1]), .tx_line(line[1]), .busy(busy[1]));
    serial_tx #(.DATA_WIDTH(8), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(1)) u_8o1 (
        .clk(clk), .sync_reset(sync_reset), .tx_if(if2.slave), .tick(tick[2]),
        .timer_clear(clr[2]), .timer_enable(en[2]), .tx_line(line[2]), .busy(busy[2]));
    serial_tx #(.DATA_WIDTH(8), .STOP_BITS(2), .PARITY_EN(0), .PARITY_ODD(0)) u_8n2 (
        .clk(clk), .sync_reset(sync_reset), .tx_if(if3.slave), .tick(tick[3]),
        .timer_clear(clr[3]), .timer_enable(en[3]), .tx_line(line[3]), .busy(busy[3]));

    // Bit timer model: held at 0 while cleared, trigger in the last cycle of each period
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (sync_reset || clr[k])
                tcnt[k] <= 3'd0;
            else if (en[k])
                tcnt[k] <= (tcnt[k] == ((k == 0) ? period0 : 3'd4) - 3'd1) ? 3'd0 : tcnt[k] + 3'd1;
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++)
            tick[k] = en[k] && (tcnt[k] == ((k == 0) ? period0 : 3'd4) - 3'd1);
        tick[0] = tick[0] | force_tick;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; exp holds the frame bits, bit 0 = start bit
    task automatic frame(input int k, input logic [7:0] d, input logic [15:0] exp,
                         input int nbits, input int per, input bit hold);
        int len;
        len = nbits * per;
        tb_data  = d;
        valid[k] = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= len; c++) begin
            @(negedge clk);
            chk($sformatf("line[%0d] d=%0h c=%0d", k, d, c), 32'(line[k]), 32'(exp[(c - 1) / per]));
            if (c == 1 || c == len) begin
                chk($sformatf("busy[%0d] c=%0d", k, c), 32'(busy[k]), 32'd1);
                chk($sformatf("ready[%0d] c=%0d", k, c), 32'(ready[k]), 32'd0);
                chk($sformatf("tenable[%0d] c=%0d", k, c), 32'(en[k]), 32'd1);
                chk($sformatf("tclear[%0d] c=%0d", k, c), 32'(clr[k]), 32'd0);
            end
            if (c == 1 && !hold) valid[k] = 1'b0;
            if (c == 10) tb_data = ~d;
        end
        @(negedge clk);
        chk($sformatf("end_busy[%0d] d=%0h", k, d), 32'(busy[k]), 32'd0);
        chk($sformatf("end_ready[%0d] d=%0h", k, d), 32'(ready[k]), 32'd1);
        chk($sformatf("end_line[%0d] d=%0h", k, d), 32'(line[k]), 32'd1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        sync_reset = 1'b0;
        chk("rst_line", 32'(line), 32'hF);
        chk("rst_ready", 32'(ready), 32'hF);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_tclear", 32'(clr), 32'hF);
        chk("rst_tenable", 32'(en), 32'h0);

        // 8N1 0xA5: 0,1,0,1,0,0,1,0,1,1
        frame(0, 8'hA5, 16'b1101001010, 10, 4, 1'b0);
        // Even parity of 0xA5 is 0, odd is 1
        frame(1, 8'hA5, 16'b10101001010, 11, 4, 1'b0);
        frame(2, 8'hA5, 16'b11101001010, 11, 4, 1'b0);
        // Two stop bits: 36 low cycles then 8 high
        frame(3, 8'h00, 16'b11000000000, 11, 4, 1'b0);

        // tx_valid held: second start 41 cycles after the first, first word not corrupted
        frame(0, 8'h3C, 16'b1001111000, 10, 4, 1'b1);
        frame(0, 8'hC3, 16'b1110000110, 10, 4, 1'b0);

        // Reset in cycle 17 (data bit 3 of 0xA5, a 0) abandons the frame
        tb_data  = 8'hA5;
        valid[0] = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            if (c == 1) valid[0] = 1'b0;
        end
        chk("pre_rst_line", 32'(line[0]), 32'd0);
        chk("pre_rst_busy", 32'(busy[0]), 32'd1);
        sync_reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_line", 32'(line[0]), 32'd1);
        chk("midrst_busy", 32'(busy[0]), 32'd0);
        chk("midrst_ready", 32'(ready[0]), 32'd1);
        chk("midrst_tclear", 32'(clr[0]), 32'd1);
        sync_reset = 1'b0;
        frame(0, 8'h5A, 16'b1010110100, 10, 4, 1'b0);

        // Spurious ticks in IDLE are ignored
        force_tick = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("idle_tick_line c=%0d", c), 32'(line[0]), 32'd1);
            chk($sformatf("idle_tick_busy c=%0d", c), 32'(busy[0]), 32'd0);
        end
        force_tick = 1'b0;

        // Tick every 7 cycles stretches every bit to 7 cycles
        period0 = 3'd7;
        @(negedge clk);
        frame(0, 8'hA5, 16'b1101001010, 10, 7, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
